scr1_pipe_mprf_arb: RTL and testbench

- Access controller between the EXU, the debug unit (HDU) and the multi-port register file (MPRF).
- After reset it clears x1..x(SIZE-1) through the MPRF write port, because the RAM MPRF variant has no reset.
- It then shares the single write port between EXU writeback and debug writes, and lends the rs2 read port to debug reads.
- Sits in the pipeline between EXU/HDU and the MPRF; MPRF rs1 is wired directly, not through this block.

---
 rtl/scr1_pipe_mprf_arb_if.sv | 43 ++++
 rtl/scr1_pipe_mprf_arb.sv | 123 ++++++++++++
 tb/tb_scr1_pipe_mprf_arb.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_pipe_mprf_arb_if.sv
// EXU / debug / MPRF signal bundle around the MPRF access arbiter.
interface scr1_pipe_mprf_arb_if #(
  parameter int MPRF_AWIDTH = 5,
  parameter int XLEN        = 32
);
  logic                   exu2arb_w_req_i;
  logic [MPRF_AWIDTH-1:0] exu2arb_rd_addr_i;
  logic [XLEN-1:0]        exu2arb_rd_data_i;
  logic                   exu2arb_rs2_req_i;
  logic [MPRF_AWIDTH-1:0] exu2arb_rs2_addr_i;
  logic                   arb2exu_ready_o;
  logic                   dbg2arb_req_i;
  logic                   dbg2arb_we_i;
  logic [MPRF_AWIDTH-1:0] dbg2arb_addr_i;
  logic [XLEN-1:0]        dbg2arb_wdata_i;
  logic                   arb2dbg_ack_o;
  logic [XLEN-1:0]        arb2dbg_rdata_o;
  logic                   arb2mprf_w_req_o;
  logic [MPRF_AWIDTH-1:0] arb2mprf_rd_addr_o;
  logic [XLEN-1:0]        arb2mprf_rd_data_o;
  logic [MPRF_AWIDTH-1:0] arb2mprf_rs2_addr_o;
  logic [XLEN-1:0]        mprf2arb_rs2_data_i;

  modport slave (
    input  exu2arb_w_req_i, exu2arb_rd_addr_i, exu2arb_rd_data_i,
           exu2arb_rs2_req_i, exu2arb_rs2_addr_i,
           dbg2arb_req_i, dbg2arb_we_i, dbg2arb_addr_i, dbg2arb_wdata_i,
           mprf2arb_rs2_data_i,
    output arb2exu_ready_o, arb2dbg_ack_o, arb2dbg_rdata_o,
           arb2mprf_w_req_o, arb2mprf_rd_addr_o, arb2mprf_rd_data_o,
           arb2mprf_rs2_addr_o
  );

  modport master (
    output exu2arb_w_req_i, exu2arb_rd_addr_i, exu2arb_rd_data_i,
           exu2arb_rs2_req_i, exu2arb_rs2_addr_i,
           dbg2arb_req_i, dbg2arb_we_i, dbg2arb_addr_i, dbg2arb_wdata_i,
           mprf2arb_rs2_data_i,
    input  arb2exu_ready_o, arb2dbg_ack_o, arb2dbg_rdata_o,
           arb2mprf_w_req_o, arb2mprf_rd_addr_o, arb2mprf_rd_data_o,
           arb2mprf_rs2_addr_o
  );
endinterface

// File: rtl/scr1_pipe_mprf_arb.sv
// MPRF access arbiter: post-reset register clear, EXU/debug sharing of the
// write port and debug borrowing of the rs2 read port.
module scr1_pipe_mprf_arb #(
  parameter int MPRF_SIZE   = 32,
  parameter int MPRF_AWIDTH = 5,
  parameter int XLEN        = 32,
  parameter int INIT_EN     = 1,
  parameter int RD_LAT      = 1,
  parameter int STARVE_LIM  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  scr1_pipe_mprf_arb_if.slave  bus
);
  localparam int SW = $clog2(STARVE_LIM + 1);

  typedef enum logic       {INIT, RUN} top_state_e;
  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_RDDATA, D_ACK} dbg_state_e;

  top_state_e             state;
  dbg_state_e             dstate;
  logic [MPRF_AWIDTH-1:0] init_cnt;
  logic                   d_we;
  logic [MPRF_AWIDTH-1:0] d_addr;
  logic [XLEN-1:0]        d_wdata;
  logic [XLEN-1:0]        d_rdata;
  logic [SW-1:0]          starve_cnt;

  logic init_wr, stall, ready, exu_wr, d_zero, d_wr_go, d_rd_go, d_grant;
  logic                   w_req;
  logic [MPRF_AWIDTH-1:0] w_addr;
  logic [XLEN-1:0]        w_data;

  // Outputs are gated by rst so the reset values hold while rst is high.
  assign init_wr = (state == INIT) && !rst;
  assign stall   = (dstate == D_WAIT) && (starve_cnt >= SW'(STARVE_LIM));
  assign ready   = (state == RUN) && !stall && !rst;
  assign exu_wr  = bus.exu2arb_w_req_i && ready && (bus.exu2arb_rd_addr_i != '0);
  assign d_zero  = (d_addr == '0);
  // x0 accesses never touch the MPRF, so they complete without a port.
  assign d_wr_go = (dstate == D_WAIT) && d_we && (d_zero || !exu_wr);
  assign d_rd_go = (dstate == D_WAIT) && !d_we &&
                   (d_zero || !bus.exu2arb_rs2_req_i || !ready);
  assign d_grant = d_wr_go || d_rd_go;

  always_comb begin
    w_req  = 1'b0;
    w_addr = '0;
    w_data = '0;
    if (init_wr) begin
      w_req  = 1'b1;
      w_addr = init_cnt;
    end else if (exu_wr) begin
      w_req  = 1'b1;
      w_addr = bus.exu2arb_rd_addr_i;
      w_data = bus.exu2arb_rd_data_i;
    end else if (d_wr_go && !d_zero) begin
      w_req  = 1'b1;
      w_addr = d_addr;
      w_data = d_wdata;
    end
  end

  assign bus.arb2mprf_w_req_o    = w_req;
  assign bus.arb2mprf_rd_addr_o  = w_addr;
  assign bus.arb2mprf_rd_data_o  = w_data;
  assign bus.arb2mprf_rs2_addr_o = (d_rd_go && !d_zero) ? d_addr : bus.exu2arb_rs2_addr_i;
  assign bus.arb2exu_ready_o     = ready;
  assign bus.arb2dbg_ack_o       = (dstate == D_ACK);
  assign bus.arb2dbg_rdata_o     = d_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= (INIT_EN != 0) ? INIT : RUN;
      init_cnt <= MPRF_AWIDTH'(1);
    end else if (state == INIT) begin
      if (init_cnt == MPRF_AWIDTH'(MPRF_SIZE - 1)) state <= RUN;
      init_cnt <= init_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dstate     <= D_IDLE;
      d_we       <= 1'b0;
      d_addr     <= '0;
      d_wdata    <= '0;
      d_rdata    <= '0;
      starve_cnt <= '0;
    end else begin
      case (dstate)
        D_IDLE: if ((state == RUN) && bus.dbg2arb_req_i) begin
          d_we    <= bus.dbg2arb_we_i;
          d_addr  <= bus.dbg2arb_addr_i;
          d_wdata <= bus.dbg2arb_wdata_i;
          dstate  <= D_WAIT;
        end
        D_WAIT: if (d_grant) begin
          starve_cnt <= '0;
          if (d_we) begin
            dstate <= D_ACK;
          end else if (d_zero) begin
            d_rdata <= '0;
            dstate  <= D_ACK;
          end else if (RD_LAT == 0) begin
            d_rdata <= bus.mprf2arb_rs2_data_i;
            dstate  <= D_ACK;
          end else begin
            dstate <= D_RDDATA;
          end
        end else if (starve_cnt < SW'(STARVE_LIM)) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
        D_RDDATA: begin
          d_rdata <= bus.mprf2arb_rs2_data_i;
          dstate  <= D_ACK;
        end
        D_ACK:   dstate <= D_IDLE;
        default: dstate <= D_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scr1_pipe_mprf_arb.sv
// Scoreboard bench for scr1_pipe_mprf_arb: u0 (INIT_EN=1, RD_LAT=1) with random
// EXU traffic, u1 (INIT_EN=0, RD_LAT=0) with directed latency checks.
module tb_scr1_pipe_mprf_arb;
  localparam int AW = 5, XL = 32, SZ = 32, LIM = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  scr1_pipe_mprf_arb_if #(.MPRF_AWIDTH(AW), .XLEN(XL)) b0 ();
  scr1_pipe_mprf_arb_if #(.MPRF_AWIDTH(AW), .XLEN(XL)) b1 ();

  scr1_pipe_mprf_arb #(.MPRF_SIZE(SZ), .MPRF_AWIDTH(AW), .XLEN(XL), .INIT_EN(1),
                       .RD_LAT(1), .STARVE_LIM(LIM)) u0 (.clk(clk), .rst(rst), .bus(b0));
  scr1_pipe_mprf_arb #(.MPRF_SIZE(SZ), .MPRF_AWIDTH(AW), .XLEN(XL), .INIT_EN(0),
                       .RD_LAT(0), .STARVE_LIM(LIM)) u1 (.clk(clk), .rst(rst), .bus(b1));

  // Register file models; contents are scrambled during reset so the clear matters.
  logic [XL-1:0] mem0 [SZ];
  logic [XL-1:0] mem1 [SZ];
  logic [XL-1:0] rs2_q0 = '0;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SZ; i++) begin
        mem0[i] <= (i == 0) ? 32'h0 : (32'hA5A5_0000 | 32'(i));
        mem1[i] <= (i == 0) ? 32'h0 : (32'h5A5A_0000 | 32'(i));
      end
    end else begin
      if (b0.arb2mprf_w_req_o) mem0[b0.arb2mprf_rd_addr_o] <= b0.arb2mprf_rd_data_o;
      if (b1.arb2mprf_w_req_o) mem1[b1.arb2mprf_rd_addr_o] <= b1.arb2mprf_rd_data_o;
    end
    rs2_q0 <= mem0[b0.arb2mprf_rs2_addr_o];
  end
  assign b0.mprf2arb_rs2_data_i = rs2_q0;
  assign b1.mprf2arb_rs2_data_i = mem1[b1.arb2mprf_rs2_addr_o];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Architectural view of u0's registers.
  logic [XL-1:0] ref_r [SZ];

  typedef struct {
    logic [XL-1:0] data;
    logic          is_rd;
    int            due;
  } exp_t;
  exp_t          dq[$];
  logic [XL-1:0] eq[$];

  logic init_done = 1'b0;
  logic rd_pend = 1'b0;
  int   last_dw_cyc = -1, last_stall_cyc = -1;
  logic [AW-1:0] last_dw_addr = '0;
  logic [XL-1:0] last_dw_data = '0;

  // Monitor: retires EXU reads, debug acks and observes the write port.
  always @(negedge clk) begin
    if (rst) begin
      rd_pend = 1'b0;
      eq.delete();
    end else begin
      if (rd_pend) chk("exu_rs2_data", b0.mprf2arb_rs2_data_i, eq.pop_front());
      rd_pend = b0.exu2arb_rs2_req_i && b0.arb2exu_ready_o;
      if (rd_pend) eq.push_back(ref_r[b0.exu2arb_rs2_addr_i]);

      if (b0.arb2dbg_ack_o) begin
        chk("dbg_ack_expected", 32'(dq.size() != 0), 32'd1);
        if (dq.size() != 0) begin
          exp_t e;
          e = dq.pop_front();
          if (e.is_rd) chk("dbg_rdata", b0.arb2dbg_rdata_o, e.data);
          if (e.due >= 0) chk("dbg_ack_cycle", 32'(cyc), 32'(e.due));
        end
      end

      if (b0.arb2mprf_w_req_o) begin
        chk("wr_not_x0", 32'(b0.arb2mprf_rd_addr_o != '0), 32'd1);
        if (init_done && !(b0.exu2arb_w_req_i && b0.arb2exu_ready_o)) begin
          last_dw_cyc  = cyc;
          last_dw_addr = b0.arb2mprf_rd_addr_o;
          last_dw_data = b0.arb2mprf_rd_data_o;
        end
      end

      if (init_done && b0.exu2arb_w_req_i && b0.arb2exu_ready_o) begin
        chk("exu_wr_pass", 32'({b0.arb2mprf_w_req_o, b0.arb2mprf_rd_addr_o}),
            32'({1'b1, b0.exu2arb_rd_addr_i}));
        chk("exu_wr_data", b0.arb2mprf_rd_data_o, b0.exu2arb_rd_data_i);
        ref_r[b0.exu2arb_rd_addr_i] = b0.exu2arb_rd_data_i;
      end
      if (init_done && !b0.arb2exu_ready_o) last_stall_cyc = cyc;
    end
  end

  // EXU stimulus; uses x8..x31 in random mode so debug owns x1..x7.
  int exu_mode = 0;
  initial begin
    b0.exu2arb_w_req_i = 0; b0.exu2arb_rd_addr_i = '0; b0.exu2arb_rd_data_i = '0;
    b0.exu2arb_rs2_req_i = 0; b0.exu2arb_rs2_addr_i = '0;
    forever begin
      @(posedge clk); #1;
      b0.exu2arb_w_req_i = 0; b0.exu2arb_rd_addr_i = '0; b0.exu2arb_rd_data_i = '0;
      b0.exu2arb_rs2_req_i = 0; b0.exu2arb_rs2_addr_i = '0;
      case (exu_mode)
        1: begin
          b0.exu2arb_w_req_i = 1;
          b0.exu2arb_rd_addr_i = 5'($urandom_range(31, 8));
          b0.exu2arb_rd_data_i = $urandom;
        end
        2: begin
          b0.exu2arb_w_req_i = 1'($urandom_range(1, 0));
          b0.exu2arb_rd_addr_i = 5'($urandom_range(31, 8));
          b0.exu2arb_rd_data_i = $urandom;
          b0.exu2arb_rs2_req_i = 1'($urandom_range(1, 0));
          b0.exu2arb_rs2_addr_i = 5'($urandom_range(31, 8));
        end
        3: begin
          b0.exu2arb_w_req_i = 1; b0.exu2arb_rd_addr_i = 5'd3;
          b0.exu2arb_rd_data_i = 32'h0000_3333;
        end
        4: begin
          b0.exu2arb_rs2_req_i = 1; b0.exu2arb_rs2_addr_i = 5'd5;
        end
        default: ;
      endcase
    end
  end

  task automatic dbg_access(input logic we, input logic [AW-1:0] a, input logic [XL-1:0] wd,
                            input int due_off, output int t0);
    exp_t e;
    int n;
    @(posedge clk); #1;
    b0.dbg2arb_req_i = 1; b0.dbg2arb_we_i = we; b0.dbg2arb_addr_i = a; b0.dbg2arb_wdata_i = wd;
    t0 = cyc;
    e.is_rd = !we;
    e.data  = (a == '0) ? '0 : ref_r[a];
    e.due   = (due_off > 0) ? t0 + due_off : -1;
    if (we && a != '0) ref_r[a] = wd;
    dq.push_back(e);
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (b0.arb2dbg_ack_o) break;
      n++;
    end
    b0.dbg2arb_req_i = 0;
    if (n >= 60) begin
      total++; bad++;
      $display("FAIL dbg_timeout: got no ack want ack within 60 cycles (addr %0d)", a);
    end
  endtask

  initial begin
    int t, n;
    b0.dbg2arb_req_i = 0; b0.dbg2arb_we_i = 0; b0.dbg2arb_addr_i = '0; b0.dbg2arb_wdata_i = '0;
    b1.exu2arb_w_req_i = 0; b1.exu2arb_rd_addr_i = '0; b1.exu2arb_rd_data_i = '0;
    b1.exu2arb_rs2_req_i = 0; b1.exu2arb_rs2_addr_i = '0;
    b1.dbg2arb_req_i = 0; b1.dbg2arb_we_i = 0; b1.dbg2arb_addr_i = '0; b1.dbg2arb_wdata_i = '0;
    for (int i = 0; i < SZ; i++) ref_r[i] = '0;

    repeat (3) @(posedge clk); #1;
    chk("rst_ready", 32'(b0.arb2exu_ready_o), 0);
    chk("rst_ack", 32'(b0.arb2dbg_ack_o), 0);
    chk("rst_rdata", b0.arb2dbg_rdata_o, 0);
    chk("rst_wreq", 32'(b0.arb2mprf_w_req_o), 0);
    chk("rst_waddr", 32'(b0.arb2mprf_rd_addr_o), 0);
    chk("rst_wdata", b0.arb2mprf_rd_data_o, 0);
    chk("rst_u1_ready", 32'(b1.arb2exu_ready_o), 0);
    rst = 0;

    // First cycle after reset: u1 (no init) is ready at once.
    @(negedge clk);
    chk("u1_ready_first", 32'(b1.arb2exu_ready_o), 1);
    n = 0;
    while (b0.arb2mprf_rd_addr_o != 5'd10 && n < 40) begin @(negedge clk); n++; end
    chk("init_reach_x10", 32'(b0.arb2mprf_rd_addr_o), 10);
    #1 rst = 1;
    #1 chk("midinit_rst_wreq", 32'({b0.arb2mprf_w_req_o, b0.arb2mprf_rd_addr_o}), 0);
    repeat (2) @(posedge clk); #1;
    rst = 0;

    for (int i = 1; i < SZ; i++) begin
      @(negedge clk);
      chk("init_wr", 32'({b0.arb2exu_ready_o, b0.arb2mprf_w_req_o, b0.arb2mprf_rd_addr_o}),
          32'({1'b0, 1'b1, 5'(i)}));
      chk("init_data", b0.arb2mprf_rd_data_o, 0);
    end
    @(negedge clk);
    chk("init_ready_rise", 32'(b0.arb2exu_ready_o), 1);
    chk("init_wreq_off", 32'(b0.arb2mprf_w_req_o), 0);
    init_done = 1;

    // u1: RD_LAT=0 write then read of x5.
    @(posedge clk); #1;
    b1.dbg2arb_req_i = 1; b1.dbg2arb_we_i = 1; b1.dbg2arb_addr_i = 5'd5;
    b1.dbg2arb_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk); chk("u1_wr_ack_early", 32'(b1.arb2dbg_ack_o), 0);
    @(negedge clk);
    chk("u1_wr", 32'({b1.arb2mprf_w_req_o, b1.arb2mprf_rd_addr_o}), 32'({1'b1, 5'd5}));
    chk("u1_wr_data", b1.arb2mprf_rd_data_o, 32'hDEAD_BEEF);
    @(negedge clk); chk("u1_wr_ack", 32'(b1.arb2dbg_ack_o), 1);
    b1.dbg2arb_req_i = 0;
    @(posedge clk); #1;
    b1.dbg2arb_req_i = 1; b1.dbg2arb_we_i = 0;
    @(negedge clk);
    @(negedge clk);
    chk("u1_rs2_addr", 32'(b1.arb2mprf_rs2_addr_o), 5);
    chk("u1_rd_ack_early", 32'(b1.arb2dbg_ack_o), 0);
    @(negedge clk);
    chk("u1_rd_ack", 32'(b1.arb2dbg_ack_o), 1);
    chk("u1_rd_data", b1.arb2dbg_rdata_o, 32'hDEAD_BEEF);
    b1.dbg2arb_req_i = 0;

    // u0: debug write/read of x5 with the EXU idle, then EXU reads it.
    dbg_access(1, 5'd5, 32'hDEAD_BEEF, 2, t);
    chk("dw5_cycle", 32'(last_dw_cyc), 32'(t + 1));
    chk("dw5_addr", 32'(last_dw_addr), 5);
    chk("dw5_data", last_dw_data, 32'hDEAD_BEEF);
    dbg_access(0, 5'd5, '0, 3, t);
    exu_mode = 4;
    repeat (2) @(posedge clk);
    exu_mode = 0;
    repeat (2) @(posedge clk);

    // Starvation: EXU writes every cycle while debug writes x7.
    exu_mode = 1;
    @(posedge clk);
    last_stall_cyc = -1;
    dbg_access(1, 5'd7, 32'h0700_0077, 10, t);
    chk("starve_stall_cyc", 32'(last_stall_cyc), 32'(t + 9));
    chk("starve_dw_cyc", 32'(last_dw_cyc), 32'(t + 9));
    chk("starve_dw_addr", 32'(last_dw_addr), 7);
    exu_mode = 0;
    repeat (2) @(posedge clk);

    // x0 write alongside an EXU write to x3.
    exu_mode = 3;
    @(posedge clk);
    last_dw_cyc = -1;
    dbg_access(1, 5'd0, 32'h0000_1234, 2, t);
    chk("x0_no_dbg_wr", 32'(last_dw_cyc), 32'(-1));
    exu_mode = 0;
    repeat (2) @(posedge clk);
    dbg_access(0, 5'd0, '0, 0, t);
    dbg_access(0, 5'd3, '0, 3, t);

    // Random mix of EXU traffic and debug accesses.
    exu_mode = 2;
    for (int k = 0; k < 40; k++)
      dbg_access(1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), $urandom, 0, t);
    exu_mode = 0;
    repeat (3) @(posedge clk);

    // Final sweep: every register as seen through the debug port.
    for (int r = 0; r < SZ; r++) dbg_access(0, 5'(r), '0, 0, t);
    repeat (2) @(posedge clk);
    chk("dq_drained", 32'(dq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
